// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped tagged branch history table with 2-bit counters
// Combinational lookup for the FD branch, one-cycle training from the X branch, perf counters.
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int LINES    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                pred_taken,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    input  logic                pred_taken_check,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    logic             valid_q [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [1:0]       ctr_q   [LINES];

    logic [31:0] br_count_q;
    logic [31:0] br_count_d;
    logic [31:0] mispred_count_q;
    logic [31:0] mispred_count_d;

    logic [IDX-1:0]   guess_idx;
    logic [TAG_W-1:0] guess_tag;
    logic             guess_hit;

    logic [IDX-1:0]   check_idx;
    logic [TAG_W-1:0] check_tag;
    logic             check_hit;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;

    // Lookup reads only registered table state, so a same-cycle update is never bypassed.
    always_comb begin
        guess_idx  = pc_guess[IDX+1:2];
        guess_tag  = pc_guess[PC_WIDTH-1:IDX+2];
        guess_hit  = valid_q[guess_idx] && (tag_q[guess_idx] == guess_tag);
        pred_taken = is_br_guess && guess_hit && ctr_q[guess_idx][1];
    end

    always_comb begin
        check_idx = pc_check[IDX+1:2];
        check_tag = pc_check[PC_WIDTH-1:IDX+2];
        check_hit = valid_q[check_idx] && (tag_q[check_idx] == check_tag);
        ctr_cur   = ctr_q[check_idx];
        ctr_d     = ctr_cur;
        if (!check_hit) begin
            ctr_d = br_taken_check ? CTR_WT : CTR_WNT;
        end else if (br_taken_check) begin
            if (ctr_cur != CTR_ST) begin
                ctr_d = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != CTR_SNT) begin
                ctr_d = ctr_cur - 2'd1;
            end
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (is_br_check) begin
            br_count_d = br_count_q + 32'd1;
            if (pred_taken_check != br_taken_check) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_SNT;
            end
        end else if (is_br_check) begin
            valid_q[check_idx] <= 1'b1;
            ctr_q[check_idx]   <= ctr_d;
        end
    end

    // Tags are meaningless while the valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (is_br_check && !check_hit) begin
            tag_q[check_idx] <= check_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped, tagged branch history table with 2-bit saturating counters. Supplies the taken/not-taken prediction for the branch in the fetch/decode (FD) stage and is trained with the resolved outcome of the branch in the execute (X) stage. It sits beside the pipeline control logic: its `pred_taken` output feeds the control logic's prediction input, and the control logic's resolved `br_taken` drives the update port. The block also keeps branch and misprediction performance counters.

## Interface
- `PC_WIDTH`, 32: PC width in bits.
- `LINES`, 8: table entries; power of two, at least 2. `IDX = log2(LINES)`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pc_guess`  in  PC_WIDTH: PC of the FD instruction.
- `is_br_guess`  in  1: the FD instruction is a conditional branch.
- `pred_taken`  out  1: prediction for `pc_guess`; combinational.
- `pc_check`  in  PC_WIDTH: PC of the X instruction.
- `is_br_check`  in  1: the X instruction is a conditional branch; qualifies the update.
- `br_taken_check`  in  1: resolved outcome of the X branch.
- `pred_taken_check`  in  1: prediction the X branch was fetched with, as pipelined by the datapath.
- `br_count`  out  32: resolved conditional branches.
- `mispred_count`  out  32: resolved branches where `pred_taken_check != br_taken_check`.

## Operation
- **Address split:** index = `pc[IDX+1:2]`; tag = `pc[PC_WIDTH-1:IDX+2]`. `pc[1:0]` is ignored.
- **Entry contents:** valid bit, tag, and a 2-bit counter. Counter encoding: 0 = strong not-taken (SNT), 1 = weak not-taken (WNT), 2 = weak taken (WT), 3 = strong taken (ST).
- **Lookup:** hit = entry valid and tag equal.
  - `pred_taken` = hit & `is_br_guess` & counter[1].
  - A miss, or `is_br_guess`=0, gives 0.
- **Update:** applies only when `is_br_check`=1.
  - Hit and taken: counter increments, saturating at 3.
  - Hit and not taken: counter decrements, saturating at 0.
  - Miss: the entry is allocated (valid=1, tag written, old entry overwritten). Counter is set to 2 if taken, 1 if not taken.
- **Performance counters:** when `is_br_check`=1, `br_count` increments. `mispred_count` increments in the same cycle when `pred_taken_check != br_taken_check`. Both wrap from 0xFFFFFFFF to 0 with no saturation.
- **Simultaneous events:** when guess and check address the same index in one cycle, the lookup returns the pre-update entry. There is no write-to-read bypass.
- **Conflicts:** aliasing PCs with the same index but a different tag evict each other. This is the only replacement policy.
- `is_br_check`=0 leaves all state unchanged, whatever the other check inputs are.
- `pred_taken` is a pure function of the current table state and the guess inputs; nothing is registered on the lookup path.

## Timing
- Lookup latency: 0 cycles, combinational from `pc_guess`/`is_br_guess` to `pred_taken`.
- Update latency: 1 cycle. A check at rising edge N is visible to lookups after edge N.
- Counter outputs come from registers and update on the same edge as the table.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits are 0 and all counters 0; tag contents are don't-care.
  - `br_count` = 0, `mispred_count` = 0.
  - `pred_taken` = 0 while `rst`=1 and until the first allocation.
  - An update coinciding with reset assertion is discarded.
- No handshake and no stall input. The pipeline presents each X branch for exactly one cycle.

## Test plan
- **Reset behaviour:** assert `rst` for 2 cycles, then guess `pc`=0x100 with `is_br_guess`=1 -> `pred_taken`=0, `br_count`=0, `mispred_count`=0.
- **Training and saturation:** check 0x100 taken (`pred_taken_check`=0) -> next-cycle guess 0x100 gives 1, `mispred_count`=1. Three more taken checks -> counter=3. One not-taken check -> still predicts 1. A second not-taken check -> predicts 0.
- **Aliasing:** with `LINES`=8, train 0x100 to ST, then check 0x120 not-taken (same index, new tag) -> guess 0x100 gives 0 (miss), guess 0x120 gives 0 (counter 1). Check 0x120 taken twice -> guess 0x120 gives 1.
- **Same-cycle read/write:** 0x100 at WNT, check 0x100 taken while guessing 0x100 -> `pred_taken`=0 in that cycle, 1 in the next.
- **Qualification and wrap:**
  - Toggle `br_taken_check` with `is_br_check`=0 for 10 cycles -> table and counters unchanged.
  - Apply 2^32 checks through a forced pre-load of `br_count`=0xFFFFFFFF plus one check -> `br_count`=0.
- **Reset mid-operation:** assert `rst` asynchronously between edges during a check burst -> outputs clear immediately, and all prior training is lost (guess 0x100 gives 0).
